// File: rtl/insn_emitter.sv
// rtl/insn_emitter.sv - symbolic op request to RV32I instruction word stream encoder
// Pseudo-ops LI and CALL expand to one or two words; illegal requests are consumed and flagged.
module insn_emitter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [31:0]      req_imm_i,
  output logic             insn_valid_o,
  input  logic             insn_ready_i,
  output logic [31:0]      insn_o,
  output logic             insn_last_o,
  output logic             err_o,
  output logic [CNT_W-1:0] emitted_cnt_o
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_MV     = 4'd1;
  localparam logic [3:0] OP_LI     = 4'd2;
  localparam logic [3:0] OP_CALL   = 4'd3;
  localparam logic [3:0] OP_J      = 4'd4;
  localparam logic [3:0] OP_RET    = 4'd5;
  localparam logic [3:0] OP_ADD    = 4'd6;
  localparam logic [3:0] OP_LW     = 4'd7;
  localparam logic [3:0] OP_SW     = 4'd8;
  localparam logic [3:0] OP_ECALL  = 4'd9;
  localparam logic [3:0] OP_EBREAK = 4'd10;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] X1 = 5'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      pend_q, pend_d;
  logic             two_q, two_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] enc_w0, enc_w1;
  logic        enc_two, enc_bad;
  logic [19:0] imm_hi;
  logic [11:0] imm_lo;
  logic        imm_fits12, imm_fits21;
  logic        req_fire, out_fire, load;

  // Rounding the upper part by bit 11 compensates for ADDI sign-extending the low part.
  assign imm_hi     = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
  assign imm_lo     = req_imm_i[11:0];
  assign imm_fits12 = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  assign imm_fits21 = (&req_imm_i[31:20]) | ~(|req_imm_i[31:20]);

  always_comb begin
    enc_w0  = 32'h0000_0013;
    enc_w1  = 32'h0000_0000;
    enc_two = 1'b0;
    enc_bad = 1'b0;
    case (req_op_i)
      OP_NOP:    enc_w0 = 32'h0000_0013;
      OP_MV:     enc_w0 = {12'd0, req_rs1_i, 3'b000, req_rd_i, OPC_OPIMM};
      OP_LI: begin
        if (imm_fits12) begin
          enc_w0 = {imm_lo, X0, 3'b000, req_rd_i, OPC_OPIMM};
        end else begin
          enc_w0  = {imm_hi, req_rd_i, OPC_LUI};
          enc_w1  = {imm_lo, req_rd_i, 3'b000, req_rd_i, OPC_OPIMM};
          enc_two = (imm_lo != 12'd0);
        end
      end
      OP_CALL: begin
        enc_w0  = {imm_hi, X1, OPC_AUIPC};
        enc_w1  = {imm_lo, X1, 3'b000, X1, OPC_JALR};
        enc_two = 1'b1;
      end
      OP_J: begin
        enc_w0  = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                   X0, OPC_JAL};
        enc_bad = req_imm_i[0] | ~imm_fits21;
      end
      OP_RET:    enc_w0 = 32'h0000_8067;
      OP_ADD:    enc_w0 = {7'd0, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, OPC_OP};
      OP_LW: begin
        enc_w0  = {imm_lo, req_rs1_i, 3'b010, req_rd_i, OPC_LOAD};
        enc_bad = ~imm_fits12;
      end
      OP_SW: begin
        enc_w0  = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010, req_imm_i[4:0], OPC_STORE};
        enc_bad = ~imm_fits12;
      end
      OP_ECALL:  enc_w0 = 32'h0000_0073;
      OP_EBREAK: enc_w0 = 32'h0010_0073;
      default:   enc_bad = 1'b1;
    endcase
  end

  assign insn_valid_o  = (state_q != IDLE);
  assign insn_o        = insn_q;
  assign insn_last_o   = last_q;
  assign err_o         = err_q;
  assign emitted_cnt_o = cnt_q;

  assign out_fire    = insn_valid_o & insn_ready_i;
  assign req_ready_o = (state_q == IDLE) | (out_fire & last_q);
  assign req_fire    = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    pend_d  = pend_q;
    two_d   = two_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire && !enc_bad) load = 1'b1;
      end
      EMIT1: begin
        if (out_fire) begin
          if (two_q) begin
            state_d = EMIT2;
            insn_d  = pend_q;
            last_d  = 1'b1;
          end else if (req_fire && !enc_bad) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (out_fire) begin
          if (req_fire && !enc_bad) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = EMIT1;
      insn_d  = enc_w0;
      pend_d  = enc_w1;
      two_d   = enc_two;
      last_d  = ~enc_two;
    end
  end

  assign err_d = req_fire & enc_bad;
  assign cnt_d = out_fire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      insn_q  <= 32'd0;
      pend_q  <= 32'd0;
      two_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      pend_q  <= pend_d;
      two_q   <= two_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_insn_emitter.sv
// tb/tb_insn_emitter.sv - table, directed and randomized checks of insn_emitter
module tb_insn_emitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
  logic [31:0] req_imm = 32'd0;
  logic        insn_valid;
  logic        insn_ready = 1'b1;
  logic [31:0] insn;
  logic        insn_last;
  logic        err;
  logic [15:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_rdy = 1'b0;

  logic [33:0] got[$];
  int          got_t[$];
  logic [33:0] exp_q[$];
  int          exp_words = 0;

  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = 33'd0;

  insn_emitter #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_imm_i(req_imm),
    .insn_valid_o(insn_valid), .insn_ready_i(insn_ready),
    .insn_o(insn), .insn_last_o(insn_last), .err_o(err),
    .emitted_cnt_o(cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Observer: every handshaken word and every error pulse becomes one entry.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("stall_hold_valid", 64'(insn_valid), 64'd1);
      check("stall_hold_word", 64'({insn_last, insn}), 64'(prev_word));
    end
    prev_stall = rst_n && insn_valid && !insn_ready;
    prev_word  = {insn_last, insn};
    if (rst_n && insn_valid && insn_ready) begin
      got.push_back({1'b0, insn_last, insn});
      got_t.push_back(cyc);
    end
    if (rst_n && err) begin
      got.push_back({1'b1, 1'b0, 32'd0});
      got_t.push_back(cyc);
    end
  end

  function automatic logic [31:0] itype(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  // Reference encoder: ISA field placement from plain arithmetic on the immediate.
  function automatic void model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output bit bad, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    longint s;
    logic [31:0] lo, hi, d, a, b;
    s  = longint'($signed(imm));
    lo = imm & 32'hFFF;
    hi = (imm + 32'h800) >> 12;
    d = 32'(rd); a = 32'(rs1); b = 32'(rs2);
    bad = 1'b0; n = 1; w0 = 32'd0; w1 = 32'd0;
    case (op)
      4'd0: w0 = 32'h13;
      4'd1: w0 = itype(0, a, 0, d, 32'h13);
      4'd2: begin
        if (s >= -2048 && s <= 2047) w0 = itype(imm, 0, 0, d, 32'h13);
        else begin
          w0 = (hi << 12) | (d << 7) | 32'h37;
          if (lo != 0) begin n = 2; w1 = itype(lo, d, 0, d, 32'h13); end
        end
      end
      4'd3: begin
        n = 2;
        w0 = (hi << 12) | (32'd1 << 7) | 32'h17;
        w1 = itype(lo, 1, 0, 1, 32'h67);
      end
      4'd4: begin
        if ((s % 2) != 0 || s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2) bad = 1'b1;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | 32'h6F;
      end
      4'd5: w0 = 32'h8067;
      4'd6: w0 = (b << 20) | (a << 15) | (d << 7) | 32'h33;
      4'd7: begin
        bad = (s < -2048 || s > 2047);
        w0 = itype(imm, a, 2, d, 32'h03);
      end
      4'd8: begin
        bad = (s < -2048 || s > 2047);
        w0 = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (32'd2 << 12) |
             ((imm & 32'h1F) << 7) | 32'h23;
      end
      4'd9:  w0 = 32'h73;
      4'd10: w0 = 32'h0010_0073;
      default: bad = 1'b1;
    endcase
    if (bad) n = 0;
  endfunction

  task automatic push_exp(input bit bad, input int n, input logic [31:0] w0, input logic [31:0] w1);
    if (bad) exp_q.push_back({1'b1, 1'b0, 32'd0});
    else if (n == 1) begin exp_q.push_back({1'b0, 1'b1, w0}); exp_words++; end
    else begin
      exp_q.push_back({1'b0, 1'b0, w0});
      exp_q.push_back({1'b0, 1'b1, w1});
      exp_words += 2;
    end
  endtask

  task automatic rnd_ready();
    if (rand_rdy) insn_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, output int waits);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      @(posedge clk); #1;
      rnd_ready();
      waits++;
      if (waits > 200) begin
        check("send_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rnd_ready();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      if (n > 150) insn_ready = 1'b1; else rnd_ready();
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(got.size()), 64'(exp_q.size()));
    insn_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string name);
    int m;
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({name, "_entry"}, 64'(got[i]), 64'(exp_q[i]));
    check({name, "_cnt"}, 64'(cnt), 64'(exp_words & 32'hFFFF));
    got.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; insn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete(); got_t.delete(); exp_q.delete(); exp_words = 0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0, w1;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input int n,
                              input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.n = n; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int w;
    bit bad;
    int n;
    logic [31:0] w0, w1, imm;
    logic [3:0] op;
    logic [31:0] edges[8];

    vecs.push_back(mk(4'd2, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 2, 32'h1234_52B7, 32'h6782_8293));
    vecs.push_back(mk(4'd2, 5'd5, 5'd0, 5'd0, 32'h0000_0FFF, 2, 32'h0000_12B7, 32'hFFF2_8293));
    vecs.push_back(mk(4'd2, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFB, 1, 32'hFFB0_0513, 32'd0));
    vecs.push_back(mk(4'd2, 5'd6, 5'd0, 5'd0, 32'h0001_0000, 1, 32'h0001_0337, 32'd0));
    vecs.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 32'h0000_1000, 2, 32'h0000_1097, 32'h0000_80E7));
    vecs.push_back(mk(4'd4, 5'd0, 5'd0, 5'd0, 32'h0000_0008, 1, 32'h0080_006F, 32'd0));
    vecs.push_back(mk(4'd4, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 0, 32'd0, 32'd0));
    vecs.push_back(mk(4'd4, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 0, 32'd0, 32'd0));
    vecs.push_back(mk(4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 0, 32'd0, 32'd0));
    vecs.push_back(mk(4'd6, 5'd3, 5'd1, 5'd2, 32'h0, 1, 32'h0020_81B3, 32'd0));
    vecs.push_back(mk(4'd7, 5'd5, 5'd2, 5'd0, 32'h8, 1, 32'h0081_2283, 32'd0));
    vecs.push_back(mk(4'd7, 5'd5, 5'd2, 5'd0, 32'h800, 0, 32'd0, 32'd0));
    vecs.push_back(mk(4'd8, 5'd0, 5'd2, 5'd6, 32'hC, 1, 32'h0061_2623, 32'd0));
    vecs.push_back(mk(4'd1, 5'd7, 5'd8, 5'd0, 32'h0, 1, 32'h0004_0393, 32'd0));
    vecs.push_back(mk(4'd9, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0000_0073, 32'd0));
    vecs.push_back(mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0000_0013, 32'd0));

    do_reset();
    @(negedge clk);
    check("rst_valid", 64'(insn_valid), 64'd0);
    check("rst_insn", 64'(insn), 64'd0);
    check("rst_last", 64'(insn_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Table vectors, one after another at full downstream throughput.
    foreach (vecs[i]) begin
      push_exp(vecs[i].n == 0, vecs[i].n, vecs[i].w0, vecs[i].w1);
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, w);
    end
    drain();
    compare_all("table");

    // CALL held by a stalled sink.
    insn_ready = 1'b0;
    send(4'd3, 5'd0, 5'd0, 5'd0, 32'h1000, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("call_stall_valid", 64'(insn_valid), 64'd1);
      check("call_stall_word", 64'({insn_last, insn}), 64'({1'b0, 32'h0000_1097}));
      check("call_stall_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    insn_ready = 1'b1;
    @(negedge clk);
    check("call_w0", 64'({insn_last, insn}), 64'({1'b0, 32'h0000_1097}));
    @(negedge clk);
    check("call_w1", 64'({insn_last, insn}), 64'({1'b1, 32'h0000_80E7}));
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_1097});
    exp_q.push_back({1'b0, 1'b1, 32'h0000_80E7});
    exp_words += 2;
    drain();
    compare_all("call");

    // Back-to-back single-word requests.
    send(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, w);
    send(4'd5, 5'd0, 5'd0, 5'd0, 32'd0, w);
    check("b2b_ret_waits", 64'(w), 64'd0);
    send(4'd10, 5'd0, 5'd0, 5'd0, 32'd0, w);
    check("b2b_ebreak_waits", 64'(w), 64'd0);
    push_exp(0, 1, 32'h13, 0);
    push_exp(0, 1, 32'h8067, 0);
    push_exp(0, 1, 32'h0010_0073, 0);
    drain();
    if (got_t.size() == 3) begin
      check("b2b_consec_1", 64'(got_t[1] - got_t[0]), 64'd1);
      check("b2b_consec_2", 64'(got_t[2] - got_t[1]), 64'd1);
    end else check("b2b_times", 64'(got_t.size()), 64'd3);
    compare_all("b2b");

    // Rejected jump: one error pulse, nothing emitted.
    send(4'd4, 5'd0, 5'd0, 5'd0, 32'd3, w);
    @(negedge clk);
    check("jerr_pulse", 64'(err), 64'd1);
    check("jerr_valid", 64'(insn_valid), 64'd0);
    @(negedge clk);
    check("jerr_pulse_end", 64'(err), 64'd0);
    check("jerr_valid2", 64'(insn_valid), 64'd0);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 32'd0});
    drain();
    compare_all("jerr");

    // Reset after the first CALL word is handshaken.
    send(4'd3, 5'd0, 5'd0, 5'd0, 32'h1000, w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid", 64'(insn_valid), 64'd0);
    check("mid_rst_cnt", 64'(cnt), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_no_word", 64'(insn_valid), 64'd0);
    @(posedge clk); #1;
    got.delete(); got_t.delete(); exp_q.delete(); exp_words = 0;

    // Randomized requests with a randomly stalling sink.
    edges[0] = 32'hFFFF_F800; edges[1] = 32'h0000_07FF; edges[2] = 32'h0000_0800;
    edges[3] = 32'hFFFF_F7FF; edges[4] = 32'h000F_FFFE; edges[5] = 32'hFFF0_0000;
    edges[6] = 32'h7FFF_F800; edges[7] = 32'hFFFF_FFFF;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      case ($urandom_range(0, 5))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = $urandom;
        2: imm = edges[$urandom_range(0, 7)];
        3: imm = $urandom & 32'hFFFF_F000;
        4: imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & 32'hFFFF_FFFE;
        default: imm = 32'($urandom_range(0, 64)) - 32'd32;
      endcase
      req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      model(op, req_rd, req_rs1, req_rs2, imm, bad, n, w0, w1);
      push_exp(bad, n, w0, w1);
      send(op, req_rd, req_rs1, req_rs2, imm, w);
    end
    rand_rdy = 1'b0;
    drain();
    compare_all("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/insn_emitter.md
Name: insn_emitter

Overview:
Encoder counterpart of the tracer's instruction decode tables. It accepts symbolic operation requests (opcode class plus rd/rs1/rs2/imm) and emits legal RV32I instruction words over a valid/ready stream. Pseudo-instructions (LI, CALL) expand to one or two words. The block sits in the bench/boot-ROM generation path, feeding self-check programs into the core's instruction memory or fetch stub.

Parameters:
CNT_W, 16, width of the emitted-word counter (wraps modulo 2^CNT_W).

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_op_i  in  4  operation code (see Behaviour)
req_rd_i  in  5  destination register
req_rs1_i  in  5  source register 1
req_rs2_i  in  5  source register 2
req_imm_i  in  32  immediate / offset
insn_valid_o  out  1  instruction word valid
insn_ready_i  in  1  downstream ready
insn_o  out  32  encoded instruction
insn_last_o  out  1  final word of the current request
err_o  out  1  one-cycle pulse: request rejected
emitted_cnt_o  out  CNT_W  count of words handshaken out

Behaviour:
- Sync active-low reset:
  - State = IDLE.
  - insn_valid_o=0, insn_o=0, insn_last_o=0, err_o=0, emitted_cnt_o=0.
  - Reset mid-expansion drops all pending words; no partial word appears after reset.
- FSM states and transitions:
  - IDLE → EMIT1 on an accepted, legal request.
  - EMIT1 on handshake → EMIT2 if two-word, else IDLE (or EMIT1 again if a new request is accepted the same cycle).
  - EMIT2 on handshake → IDLE (or EMIT1 on a same-cycle accept).
- req_ready_o = IDLE || (insn_valid_o && insn_last_o && insn_ready_i). This is a combinational path from insn_ready_i and gives full throughput of one word per cycle.
- Latency: first word is valid the cycle after acceptance.
- insn_o and insn_last_o stay stable while insn_valid_o=1 and insn_ready_i=0.
- Ops and encodings:
  - 0 NOP → 0x00000013.
  - 1 MV → ADDI rd,rs1,0.
  - 2 LI rd,imm:
    - If imm in [-2048,2047]: ADDI rd,x0,imm.
    - Else: hi=(imm+0x800)[31:12], lo=imm[11:0] (32-bit wrap arithmetic); emit LUI rd,hi, then ADDI rd,rd,lo only if lo≠0.
  - 3 CALL off → AUIPC x1,hi; JALR x1,x1,lo. Always two words; same hi/lo split as LI.
  - 4 J off → JAL x0,off.
  - 5 RET → 0x00008067.
  - 6 ADD → R-type, funct7=0, funct3=000.
  - 7 LW → I-type, funct3=010.
  - 8 SW → S-type, funct3=010.
  - 9 ECALL → 0x00000073.
  - 10 EBREAK → 0x00100073.
- Errors, checked at acceptance:
  - Conditions: op≥11; J with off[0]=1 or off outside [-2^20, 2^20-2]; LW/SW imm outside [-2048,2047].
  - Response: the request is consumed, err_o pulses the next cycle, no word is emitted, FSM stays IDLE.
- emitted_cnt_o increments on each insn_valid_o&&insn_ready_i and wraps to 0.
- rd=x0 is legal for all ops and is encoded literally.

Test Plan:
- LI x5,0x12345678 → 0x123452B7 (last=0), then 0x67828293 (last=1); emitted_cnt_o=2.
- LI x5,0x00000FFF → 0x000012B7, then 0xFFF28293. LI x10,-5 → single word 0xFFB00513, last=1. LI x6,0x00010000 → single word 0x00010337.
- CALL 0x1000 with insn_ready_i=0 for 3 cycles → 0x00001097 held stable and req_ready_o=0 throughout, then 0x000080E7.
- Back-to-back NOP, RET, EBREAK with insn_ready_i=1 → 0x00000013, 0x00008067, 0x00100073 on consecutive cycles; req_ready_o stays high.
- J off=3 → err_o pulse, insn_valid_o never asserts. J off=8 → 0x0080006F. Op=15 → err_o pulse.
- rst_ni=0 after the first CALL word is handshaken → next cycle insn_valid_o=0, emitted_cnt_o=0, req_ready_o=1.
